// File: rtl/floo_pkg.sv
// Shared NoC flit types. The arbiter only looks at hdr.last; the rest of the flit
// travels through it unchanged.
package floo_pkg;

  typedef struct packed {
    logic [3:0] dst_id;
    logic       last;
  } hdr_t;

  typedef struct packed {
    hdr_t        hdr;
    logic [31:0] payload;
  } flit_t;

endpackage

// File: rtl/floo_credit_counter.sv
// Downstream credit tracker. It is decremented on every flit sent and incremented on
// every slot returned. A return while all credits are present is a protocol error.
module floo_credit_counter #(
  parameter int unsigned NumCredits = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              consume_i,
  input  logic                              return_i,
  output logic [$clog2(NumCredits+1)-1:0]   count_o,
  output logic                              avail_o
);

  typedef logic [$clog2(NumCredits+1)-1:0] cnt_t;
  localparam cnt_t Max = cnt_t'(NumCredits);

  cnt_t r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= Max;
    end else if (consume_i && !return_i) begin
      r_count <= r_count - cnt_t'(1);
    end else if (!consume_i && return_i && (r_count != Max)) begin
      r_count <= r_count + cnt_t'(1);
    end
  end

  assign count_o = r_count;
  assign avail_o = (r_count != '0);

  assert property (@(posedge clk_i) disable iff (!rst_ni) return_i |-> (r_count != Max));
  assert property (@(posedge clk_i) disable iff (!rst_ni) r_count <= Max);

endmodule

// File: rtl/floo_credit_wormhole_arbiter.sv
// Wormhole round-robin arbiter onto one credit-controlled link with a registered output.
// state    | meaning
// IDLE     | no packet open; round-robin search from rr_ptr+1 picks the next head flit
// LOCKED   | packet from lock_idx in flight; only that route may send until its last flit
module floo_credit_wormhole_arbiter #(
  parameter int unsigned NumRoutes  = 2,
  parameter int unsigned NumCredits = 4,
  parameter type         flit_t     = floo_pkg::flit_t
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumRoutes-1:0]             valid_i,
  output logic [NumRoutes-1:0]             ready_o,
  input  flit_t [NumRoutes-1:0]            data_i,
  output logic                             valid_o,
  output flit_t                            data_o,
  input  logic                             credit_i,
  output logic [$clog2(NumCredits+1)-1:0]  credits_o,
  output logic                             locked_o
);

  localparam int unsigned IdxW = (NumRoutes > 1) ? $clog2(NumRoutes) : 1;
  typedef logic [IdxW-1:0] idx_t;
  typedef logic [$clog2(NumCredits+1)-1:0] cnt_t;

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  logic [0:0] r_state;
  idx_t       r_lock_idx;
  idx_t       r_rr_ptr;
  logic       r_valid_o;
  flit_t      r_data_o;

  idx_t w_hi_idx, w_lo_idx, w_rr_idx, w_gnt_idx;
  logic w_hi_found, w_lo_found;
  logic w_gnt_valid, w_avail, w_send, w_last;
  cnt_t w_count;

  // Lowest valid index above rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    for (int i = int'(NumRoutes) - 1; i >= 0; i--) begin
      if (valid_i[i]) begin
        w_lo_idx   = idx_t'(i);
        w_lo_found = 1'b1;
        if (idx_t'(i) > r_rr_ptr) begin
          w_hi_idx   = idx_t'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    w_rr_idx = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  always_comb begin
    if (r_state == StLocked) begin
      w_gnt_idx   = r_lock_idx;
      w_gnt_valid = valid_i[r_lock_idx];
    end else begin
      w_gnt_idx   = w_rr_idx;
      w_gnt_valid = w_lo_found;
    end
  end

  assign w_send = w_gnt_valid && w_avail;
  assign w_last = data_i[w_gnt_idx].hdr.last;

  always_comb begin
    ready_o = '0;
    if (w_send) begin
      ready_o[w_gnt_idx] = 1'b1;
    end
  end

  // Priority only moves when a packet closes, so a locked route cannot be preempted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= StIdle;
      r_lock_idx <= '0;
      r_rr_ptr   <= idx_t'(NumRoutes - 1);
    end else if (w_send) begin
      if (r_state == StIdle) begin
        if (w_last) begin
          r_rr_ptr <= w_gnt_idx;
        end else begin
          r_state    <= StLocked;
          r_lock_idx <= w_gnt_idx;
        end
      end else if (w_last) begin
        r_state  <= StIdle;
        r_rr_ptr <= r_lock_idx;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid_o <= 1'b0;
      r_data_o  <= '0;
    end else begin
      r_valid_o <= w_send;
      if (w_send) begin
        r_data_o <= data_i[w_gnt_idx];
      end
    end
  end

  floo_credit_counter #(
    .NumCredits (NumCredits)
  ) u_credit_counter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .consume_i (w_send),
    .return_i  (credit_i),
    .count_o   (w_count),
    .avail_o   (w_avail)
  );

  assign valid_o   = r_valid_o;
  assign data_o    = r_data_o;
  assign credits_o = w_count;
  assign locked_o  = (r_state == StLocked);

  for (genvar gi = 0; gi < NumRoutes; gi++) begin : g_stable
    assert property (@(posedge clk_i) disable iff (!rst_ni)
      (valid_i[gi] && !ready_o[gi]) |=> (valid_i[gi] && $stable(data_i[gi])));
  end

endmodule

// File: tb/tb_floo_credit_wormhole_arbiter.sv
// Directed and random bench for the wormhole arbiter: reference-model scoreboard on the
// link plus per-route ordering, packet-integrity and fairness checks.
module tb_floo_credit_wormhole_arbiter;
  import floo_pkg::*;

  localparam int NR = 2;
  localparam int NC = 4;
  localparam int CW = $clog2(NC + 1);

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic [NR-1:0]  valid_i = '0;
  logic [NR-1:0]  ready_o;
  flit_t [NR-1:0] data_i = '0;
  logic           valid_o;
  flit_t          data_o;
  logic           credit_i = 1'b0;
  logic [CW-1:0]  credits_o;
  logic           locked_o;

  always #5 clk_i = ~clk_i;

  floo_credit_wormhole_arbiter #(
    .NumRoutes  (NR),
    .NumCredits (NC),
    .flit_t     (flit_t)
  ) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .data_i    (data_i),
    .valid_o   (valid_o),
    .data_o    (data_o),
    .credit_i  (credit_i),
    .credits_o (credits_o),
    .locked_o  (locked_o)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model and scoreboard state
  flit_t         exp_q[$];
  int            m_locked, m_lock, m_rr, m_cred;
  logic [NR-1:0] hs_seen = '0;
  int            out_cnt = 0;
  int            cyc = 0;
  int            out_route[$];
  int            out_cyc[$];
  logic          last_last = 1'b0;
  int            exp_seq[NR];
  int            wait_cnt[NR];
  int            prev_open, prev_route;
  int            mg, mr;
  logic          mgv, msnd;
  flit_t         me, mf;

  always @(negedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      m_locked = 0; m_lock = 0; m_rr = NR - 1; m_cred = NC;
      exp_q.delete();
      hs_seen = '0;
      prev_open = 0; prev_route = 0;
      for (int q = 0; q < NR; q++) begin exp_seq[q] = 0; wait_cnt[q] = 0; end
    end else begin
      check("valid_o", 64'(valid_o), 64'(exp_q.size() > 0));
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        if (valid_o) begin
          check("data_o", 64'(data_o), 64'(me));
          mf = data_o;
          mr = int'(mf.payload[31:28]);
          out_cnt++;
          out_route.push_back(mr);
          out_cyc.push_back(cyc);
          last_last = mf.hdr.last;
          if (prev_open != 0) check("unmixed", 64'(mr), 64'(prev_route));
          check("route_id", 64'(mr < NR), 64'(1));
          if (mr < NR) begin
            check("seq_order", 64'(mf.payload[11:0]), 64'(exp_seq[mr]));
            exp_seq[mr] = mf.hdr.last ? 0 : exp_seq[mr] + 1;
            if (mf.hdr.last) begin
              for (int q = 0; q < NR; q++) begin
                if (q != mr && valid_i[q]) begin
                  wait_cnt[q]++;
                  check("fairness", 64'(wait_cnt[q] <= NR - 1), 64'(1));
                end
              end
            end
          end
          prev_open  = mf.hdr.last ? 0 : 1;
          prev_route = mr;
        end
      end
      check("credits_o", 64'(credits_o), 64'(m_cred));
      check("locked_o", 64'(locked_o), 64'(m_locked));

      mgv = 1'b0; mg = 0;
      if (m_locked != 0) begin
        mg = m_lock; mgv = valid_i[m_lock];
      end else begin
        for (int k = NR; k >= 1; k--) begin
          if (valid_i[(m_rr + k) % NR]) begin mg = (m_rr + k) % NR; mgv = 1'b1; end
        end
      end
      msnd = mgv && (m_cred != 0);
      check("ready_o", 64'(ready_o), msnd ? 64'(1) << mg : 64'(0));

      hs_seen = valid_i & ready_o;
      for (int q = 0; q < NR; q++) if (ready_o[q]) wait_cnt[q] = 0;

      if (msnd) exp_q.push_back(data_i[mg]);
      if (msnd && !credit_i) m_cred--;
      else if (!msnd && credit_i && m_cred < NC) m_cred++;
      if (msnd) begin
        if (m_locked != 0) begin
          if (data_i[mg].hdr.last) begin m_locked = 0; m_rr = mg; end
        end else if (data_i[mg].hdr.last) begin
          m_rr = mg;
        end else begin
          m_locked = 1; m_lock = mg;
        end
      end
    end
  end

  // upstream sources
  int rem[NR], sq[NR], ln[NR], pk[NR], gap[NR], bub_arm[NR];
  int cmode = 0;
  bit rnd_on = 1'b0;

  function automatic flit_t mk(input int r);
    flit_t f;
    f = '0;
    f.hdr.dst_id = 4'(r);
    f.hdr.last   = (sq[r] == ln[r] - 1);
    f.payload    = {4'(r), 4'(ln[r]), 12'(pk[r]), 12'(sq[r])};
    return f;
  endfunction

  task automatic load(input int r, input int l);
    rem[r] = l; ln[r] = l; sq[r] = 0; pk[r]++;
    valid_i[r] = 1'b1;
    data_i[r]  = mk(r);
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
    for (int r = 0; r < NR; r++) begin
      if (hs_seen[r]) begin
        rem[r]--; sq[r]++;
        if (bub_arm[r] > 0) begin
          gap[r] = bub_arm[r]; bub_arm[r] = 0;
        end else if (rnd_on && rem[r] > 0 && $urandom_range(0, 7) == 0) begin
          gap[r] = $urandom_range(1, 3);
        end
      end
      if (valid_i[r] && !hs_seen[r]) begin
        // unaccepted flit must be held
      end else if (gap[r] > 0) begin
        valid_i[r] = 1'b0; gap[r]--;
      end else if (rem[r] > 0) begin
        valid_i[r] = 1'b1; data_i[r] = mk(r);
      end else if (rnd_on && $urandom_range(0, 2) == 0) begin
        load(r, $urandom_range(1, 5));
      end else begin
        valid_i[r] = 1'b0;
      end
    end
    credit_i = ((cmode == 1) && (m_cred < NC)) ||
               ((cmode == 2) && (m_cred < NC) && ($urandom_range(0, 2) != 0));
  endtask

  task automatic clear_src();
    for (int r = 0; r < NR; r++) begin rem[r] = 0; gap[r] = 0; bub_arm[r] = 0; end
    valid_i = '0; credit_i = 1'b0; cmode = 0; rnd_on = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    clear_src();
    tick(); tick();
    rst_ni = 1'b1;
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while (n < maxc && (rem[0] > 0 || rem[1] > 0 || valid_i != '0 || valid_o || exp_q.size() > 0)) begin
      tick(); n++;
    end
    check("drain_timeout", 64'(n < maxc), 64'(1));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  int b, b2;

  initial begin
    for (int r = 0; r < NR; r++) begin pk[r] = 0; sq[r] = 0; ln[r] = 1; end
    do_reset();

    // reset state
    #1;
    check("rst_valid_o", 64'(valid_o), 64'(0));
    check("rst_data_o", 64'(data_o), 64'(0));
    check("rst_credits", 64'(credits_o), 64'(NC));
    check("rst_locked", 64'(locked_o), 64'(0));
    check("rst_ready", 64'(ready_o), 64'(0));

    // 1: one route, 6-flit packet, credits run out after 4 flits
    b = out_cnt;
    load(0, 6);
    repeat (6) tick();
    check("t1_four_out", 64'(out_cnt - b), 64'(4));
    if (out_cyc.size() >= 4)
      check("t1_consecutive", 64'(out_cyc[out_cyc.size()-1] - out_cyc[out_cyc.size()-4]), 64'(3));
    check("t1_credits_zero", 64'(credits_o), 64'(0));
    #1;
    check("t1_stall_ready", 64'(ready_o), 64'(0));
    check("t1_locked_mid", 64'(locked_o), 64'(1));
    credit_i = 1'b1;
    tick();
    credit_i = 1'b1;
    tick();
    check("t1_locked_before_last", 64'(locked_o), 64'(1));
    tick();
    check("t1_locked_dropped", 64'(locked_o), 64'(0));
    tick(); tick();
    check("t1_six_out", 64'(out_cnt - b), 64'(6));
    check("t1_last_flag", 64'(last_last), 64'(1));
    check("t1_credits_after", 64'(credits_o), 64'(0));
    cmode = 1;
    repeat (6) tick();
    check("t1_credits_refill", 64'(credits_o), 64'(NC));

    // 2: contention from reset, packets stay whole, priority rotates
    do_reset();
    cmode = 1;
    b = out_route.size();
    load(0, 3); load(1, 3);
    drain(60);
    check("t2_count", 64'(out_route.size() - b), 64'(6));
    if (out_route.size() >= b + 6)
      for (int i = 0; i < 6; i++) check("t2_order", 64'(out_route[b+i]), 64'((i < 3) ? 0 : 1));
    b2 = out_route.size();
    load(0, 2); load(1, 2);
    drain(60);
    check("t2_next_first", 64'((out_route.size() > b2) ? out_route[b2] : -1), 64'(0));

    // 3: bubble on the locked route blocks everyone
    do_reset();
    cmode = 1;
    b2 = out_route.size();
    load(0, 4); load(1, 2);
    bub_arm[0] = 3;
    b = 0;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      check("t3_bubble_ready", 64'(ready_o), 64'(0));
      check("t3_bubble_lock", 64'(locked_o), 64'(1));
      if (k == 1) b = out_cnt;
    end
    tick(); tick();
    check("t3_no_out_in_bubble", 64'(out_cnt), 64'(b));
    drain(60);
    check("t3_count", 64'(out_route.size() - b2), 64'(6));
    if (out_route.size() >= b2 + 6)
      for (int i = 0; i < 6; i++) check("t3_order", 64'(out_route[b2+i]), 64'((i < 4) ? 0 : 1));

    // 4: send and credit return in the same cycle at one credit
    do_reset();
    load(0, 5);
    tick(); tick(); tick();
    check("t4_credits_one", 64'(credits_o), 64'(1));
    credit_i = 1'b1;
    #1;
    check("t4_ready_at_one", 64'(ready_o[0]), 64'(1));
    tick();
    check("t4_credits_hold", 64'(credits_o), 64'(1));
    #1;
    check("t4_next_ready", 64'(ready_o[0]), 64'(1));
    tick();
    check("t4_credits_zero", 64'(credits_o), 64'(0));
    check("t4_valid_o", 64'(valid_o), 64'(1));
    cmode = 1;
    drain(60);

    // 5: asynchronous reset while locked
    do_reset();
    load(0, 4);
    tick(); tick();
    check("t5_locked", 64'(locked_o), 64'(1));
    check("t5_credits_two", 64'(credits_o), 64'(2));
    #2;
    rst_ni = 1'b0;
    clear_src();
    #1;
    check("t5_rst_valid_o", 64'(valid_o), 64'(0));
    check("t5_rst_credits", 64'(credits_o), 64'(NC));
    check("t5_rst_locked", 64'(locked_o), 64'(0));
    check("t5_rst_ready", 64'(ready_o), 64'(0));
    tick(); tick();
    rst_ni = 1'b1;

    // 6: random traffic and credit returns
    tick();
    b = out_cnt;
    rnd_on = 1'b1;
    cmode = 2;
    repeat (10000) tick();
    rnd_on = 1'b0;
    cmode = 1;
    drain(400);
    repeat (8) tick();
    check("t6_progress", 64'((out_cnt - b) > 1000), 64'(1));
    check("t6_credits_full", 64'(credits_o), 64'(NC));
    check("t6_unlocked", 64'(locked_o), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
